// File: rtl/avalon_write_master_pkg.sv
// Shared types and helpers for the Avalon-MM write master slice.
// Contains the FSM state encoding and the bytes-per-word derivation.
package avalon_write_master_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/write_master_fifo.sv
// Synchronous show-ahead FIFO buffering user words ahead of the Avalon write port.
// The head word is valid whenever empty is low; a pop advances it on the next edge.
module write_master_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push_ok;
    logic                  pop_ok;

    // Full is judged on the registered count, so a push coinciding with a pop from a full FIFO is still refused.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; flushing the pointers makes its contents unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/avalon_write_master.sv
// Drains buffered user words onto an Avalon-MM write port for a commanded byte length,
// incrementing the byte address per beat unless fixed-location mode was latched at go.
module avalon_write_master
    import avalon_write_master_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int LENGTH_WIDTH    = 32,
    parameter int FIFO_DEPTH      = 32,
    parameter int FIFO_DEPTH_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    control_fixed_location,
    input  logic [ADDR_WIDTH-1:0]   control_write_base,
    input  logic [LENGTH_WIDTH-1:0] control_write_length,
    input  logic                    control_go,
    output logic                    control_done,
    input  logic                    user_write_buffer,
    input  logic [DATA_WIDTH-1:0]   user_buffer_input_data,
    output logic                    user_buffer_full,
    output logic [ADDR_WIDTH-1:0]   master_address,
    output logic                    master_write,
    output logic [DATA_WIDTH/8-1:0] master_byteenable,
    output logic [DATA_WIDTH-1:0]   master_writedata,
    input  logic                    master_waitrequest
);

    localparam int unsigned BYTES = bytes_per_word(DATA_WIDTH);
    localparam logic [LENGTH_WIDTH-1:0] LEN_MASK  = LENGTH_WIDTH'(BYTES - 1);
    localparam logic [LENGTH_WIDTH-1:0] LEN_STEP  = LENGTH_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0]   ADDR_STEP = ADDR_WIDTH'(BYTES);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   address;
    logic [LENGTH_WIDTH-1:0] remaining;
    logic                    fixed_location;
    logic [LENGTH_WIDTH-1:0] go_length;
    logic                    fifo_empty;
    logic                    beat;

    // Partial trailing words are dropped: only whole words are ever transferred.
    assign go_length = control_write_length & ~LEN_MASK;

    assign master_write      = (state == RUN) && !fifo_empty;
    assign beat              = master_write && !master_waitrequest;
    assign control_done      = (state == IDLE);
    assign master_address    = address;
    assign master_byteenable = '1;

    write_master_fifo #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (user_write_buffer),
        .push_data (user_buffer_input_data),
        .pop       (beat),
        .head      (master_writedata),
        .full      (user_buffer_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            address        <= '0;
            remaining      <= '0;
            fixed_location <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (control_go && go_length != '0) begin
                        address        <= control_write_base;
                        remaining      <= go_length;
                        fixed_location <= control_fixed_location;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (beat) begin
                        remaining <= remaining - LEN_STEP;
                        if (!fixed_location) address <= address + ADDR_STEP;
                        if (remaining == LEN_STEP) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_write_master.sv
// Scoreboard bench for avalon_write_master: expected beats are queued as words are pushed
// and compared by a negedge monitor as the Avalon port accepts them.
module tb_avalon_write_master;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        control_fixed_location = 1'b0;
    logic [31:0] control_write_base = '0;
    logic [31:0] control_write_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        user_write_buffer = 1'b0;
    logic [31:0] user_buffer_input_data = '0;
    logic        user_buffer_full;
    logic [31:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic        master_waitrequest = 1'b0;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    beat_count = 0;
    bit    mon_en = 1'b1;
    beat_t sb[$];

    avalon_write_master dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_input_data (user_buffer_input_data),
        .user_buffer_full       (user_buffer_full),
        .master_address         (master_address),
        .master_write           (master_write),
        .master_byteenable      (master_byteenable),
        .master_writedata       (master_writedata),
        .master_waitrequest     (master_waitrequest)
    );

    always #5 clk = ~clk;

    // Monitor: beats are decided at the next rising edge, so inspect them half a cycle earlier.
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    beat_t       exp_beat;

    always @(negedge clk) begin
        if (mon_en && reset === 1'b0) begin
            if (prev_stall) begin
                tests_run++;
                if (master_write !== 1'b1 || master_address !== prev_addr || master_writedata !== prev_data) begin
                    tests_failed++;
                    $display("FAIL stall_hold: write=%b addr=%h data=%h, required write=1 addr=%h data=%h",
                             master_write, master_address, master_writedata, prev_addr, prev_data);
                end
            end
            if (master_write === 1'b1 && master_waitrequest === 1'b0) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_beat: addr=%h data=%h, required no beat", master_address, master_writedata);
                end else begin
                    exp_beat = sb.pop_front();
                    if (master_address !== exp_beat.addr || master_writedata !== exp_beat.data ||
                        master_byteenable !== 4'hF) begin
                        tests_failed++;
                        $display("FAIL beat: addr=%h data=%h be=%h, required addr=%h data=%h be=f",
                                 master_address, master_writedata, master_byteenable, exp_beat.addr, exp_beat.data);
                    end
                end
                beat_count++;
            end
            prev_stall = (master_write === 1'b1 && master_waitrequest === 1'b1);
            prev_addr  = master_address;
            prev_data  = master_writedata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_word(input logic [31:0] d);
        user_write_buffer      = 1'b1;
        user_buffer_input_data = d;
        @(posedge clk);
        #1 user_write_buffer = 1'b0;
    endtask

    task automatic start_cmd(input logic [31:0] base, input logic [31:0] len, input logic fixed);
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        @(posedge clk);
        #1 control_go = 1'b0;
        control_fixed_location = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (control_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s_done: timed out after %0d cycles, control_done=%b required 1", name, max_cycles, control_done);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle_outputs(input string name);
        tests_run++;
        if (control_done !== 1'b1 || master_write !== 1'b0 || master_address !== 32'h0 || user_buffer_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: done=%b write=%b addr=%h full=%b, required done=1 write=0 addr=0 full=0",
                     name, control_done, master_write, master_address, user_buffer_full);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        expect_idle_outputs("reset_state");
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_word();
        sb.push_back('{addr: 32'h1000_0000, data: 32'd13});
        push_word(32'd13);
        start_cmd(32'h1000_0000, 32'd4, 1'b0);
        @(negedge clk);
        tests_run++;
        if (control_done !== 1'b0 || master_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL go_latency: done=%b write=%b, required done=0 write=1", control_done, master_write);
        end
        wait_done(10, "single_word");
    endtask

    task automatic test_burst_stalls();
        bit finished = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{addr: 32'h100 + 32'(4 * i), data: 32'(i + 1)});
            push_word(32'(i + 1));
        end
        master_waitrequest = 1'b1;
        start_cmd(32'h100, 32'd32, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (control_done === 1'b1) begin
                finished = 1'b1;
                break;
            end
            master_waitrequest = ~master_waitrequest;
        end
        master_waitrequest = 1'b0;
        tests_run++;
        if (!finished || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL burst_stalls: finished=%b outstanding=%0d, required finished=1 outstanding=0", finished, sb.size());
        end
    endtask

    task automatic test_fixed_location();
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{addr: 32'h200, data: 32'hA0 + 32'(i)});
            push_word(32'hA0 + 32'(i));
        end
        start_cmd(32'h200, 32'd16, 1'b1);
        wait_done(20, "fixed_location");
    endtask

    task automatic test_full_drain();
        for (int i = 0; i < 33; i++) begin
            if (i < 32) sb.push_back('{addr: 32'h400 + 32'(4 * i), data: 32'h3000 + 32'(i)});
            push_word(32'h3000 + 32'(i));
            if (i >= 31) begin
                tests_run++;
                if (user_buffer_full !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL full_after_push%0d: full=%b, required 1", i + 1, user_buffer_full);
                end
            end
        end
        start_cmd(32'h400, 32'd128, 1'b0);
        tests_run++;
        if (user_buffer_full !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_before_first_beat: full=%b, required 1", user_buffer_full);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (user_buffer_full !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_after_first_beat: full=%b, required 0", user_buffer_full);
        end
        wait_done(50, "full_drain");
        // The 33rd word must have been dropped, so a new command finds the FIFO empty.
        start_cmd(32'h0, 32'd4, 1'b0);
        @(negedge clk);
        tests_run++;
        if (master_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL overflow_dropped: write=%b, required 0", master_write);
        end
        @(posedge clk);
        #1;
        sb.push_back('{addr: 32'h0, data: 32'hABCD});
        push_word(32'hABCD);
        wait_done(10, "overflow_followup");
    endtask

    task automatic test_empty_mid_run();
        logic [31:0] base = 32'hFFFF_FF80;
        start_cmd(base, 32'd256, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (master_write !== 1'b0 || control_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL empty_run: write=%b done=%b, required write=0 done=0", master_write, control_done);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            sb.push_back('{addr: base + 32'(4 * i), data: 32'h1000 + 32'(i)});
            push_word(32'h1000 + 32'(i));
        end
        wait_done(20, "empty_mid_run");
    endtask

    task automatic test_zero_length();
        int start_beats;
        push_word(32'h55);
        start_beats = beat_count;
        start_cmd(32'h600, 32'd0, 1'b0);
        start_cmd(32'h600, 32'd3, 1'b0);
        repeat (3) @(negedge clk);
        tests_run++;
        if (control_done !== 1'b1 || master_write !== 1'b0 || beat_count != start_beats) begin
            tests_failed++;
            $display("FAIL zero_length: done=%b write=%b beats=%0d, required done=1 write=0 beats=%0d",
                     control_done, master_write, beat_count, start_beats);
        end
        @(posedge clk);
        #1;
        // A length of 7 truncates to one word and consumes the word left over from above.
        sb.push_back('{addr: 32'h604, data: 32'h55});
        start_cmd(32'h604, 32'd7, 1'b0);
        wait_done(10, "truncated_length");
    endtask

    task automatic test_reset_mid_run();
        int  start_beats = beat_count;
        bit  reached = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{addr: 32'h800 + 32'(4 * i), data: 32'h70 + 32'(i)});
            push_word(32'h70 + 32'(i));
        end
        start_cmd(32'h800, 32'd32, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (beat_count == start_beats + 3) begin
                reached = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!reached) begin
            tests_failed++;
            $display("FAIL reset_mid_run_beats: beats=%0d, required %0d", beat_count - start_beats, 3);
        end
        @(posedge clk);
        #1 mon_en = 1'b0;
        reset = 1'b1;
        master_waitrequest = 1'b1;
        @(posedge clk);
        @(negedge clk);
        expect_idle_outputs("reset_mid_run");
        @(posedge clk);
        #1 reset = 1'b0;
        master_waitrequest = 1'b0;
        sb.delete();
        mon_en = 1'b1;
        start_cmd(32'h900, 32'd4, 1'b0);
        repeat (3) @(negedge clk);
        tests_run++;
        if (master_write !== 1'b0 || control_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL fifo_flushed: write=%b done=%b, required write=0 done=0", master_write, control_done);
        end
        @(posedge clk);
        #1;
        sb.push_back('{addr: 32'h900, data: 32'hEE});
        push_word(32'hEE);
        wait_done(10, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst_stalls();
        test_fixed_location();
        test_full_drain();
        test_empty_mid_run();
        test_zero_length();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/avalon_write_master.md
# avalon_write_master

Downstream stage for the button-driven memory-access controller. Accepts a transfer command (base, length, go) plus a stream of data words pushed into an internal FIFO. Drains that FIFO onto an Avalon-MM master write port one word per accepted beat, incrementing the address unless fixed-location mode is selected, and raises done when the commanded length has been written.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- LENGTH_WIDTH, 32, transfer length width in bytes.
- FIFO_DEPTH, 32, user buffer depth in words; power of 2.
- FIFO_DEPTH_LOG2, 5, log2(FIFO_DEPTH).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- control_fixed_location  in  1  1: every word goes to the base address.
- control_write_base  in  ADDR_WIDTH  byte start address, latched on go.
- control_write_length  in  LENGTH_WIDTH  bytes to write, latched on go.
- control_go  in  1  single-cycle start pulse.
- control_done  out  1  1 when idle.
- user_write_buffer  in  1  push strobe.
- user_buffer_input_data  in  DATA_WIDTH  push data.
- user_buffer_full  out  1  FIFO holds FIFO_DEPTH words.
- master_address  out  ADDR_WIDTH  Avalon byte address.
- master_write  out  1  Avalon write request.
- master_byteenable  out  DATA_WIDTH/8  constant all ones.
- master_writedata  out  DATA_WIDTH  FIFO head word.
- master_waitrequest  in  1  Avalon stall.

## Operation
- BYTES = DATA_WIDTH/8. Length low log2(BYTES) bits ignored (truncated to whole words).
- States: IDLE, RUN.
- IDLE: control_done=1, master_write=0. control_go with truncated length ≥ BYTES: latch base into address register, length into remaining counter, go to RUN. control_go with truncated length 0: stay IDLE, no writes.
- RUN: control_done=0; control_go ignored. master_write = FIFO non-empty. Beat accepted when master_write && !master_waitrequest: pop FIFO; remaining -= BYTES; address += BYTES unless fixed_location latched as 1. Beat accepted with remaining == BYTES → IDLE.
- FIFO empty in RUN: master_write=0, stay RUN (no timeout).
- FIFO: synchronous, show-ahead. Push when user_write_buffer && !user_buffer_full, in any state (upstream fills before go). Push while full dropped silently. Push+pop same cycle: count unchanged; when full, push still blocked by full that cycle.
- Words left in FIFO after done remain for the next command.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset (sync, dominant over all inputs): state IDLE, FIFO flushed, control_done=1, master_write=0, master_address=0, user_buffer_full=0, master_writedata don't-care, master_byteenable all ones. Reset mid-RUN aborts the transfer; master_write low the cycle after reset is sampled.
- go accepted in cycle t → control_done low and master_write eligible from t+1.
- Word pushed in cycle t → visible at FIFO head / counted from t+1.
- Throughput: one beat per cycle while FIFO non-empty and waitrequest low.
- During waitrequest: address, writedata, write held stable.
- Final beat accepted in cycle t → control_done=1 at t+1.
- user_buffer_full deasserts the cycle after a pop from a full FIFO.

## Structure
- Shared package: state encoding (IDLE, RUN), BYTES derivation helper.
- One sub-module: write_master_fifo (synchronous show-ahead FIFO, push/pop/full/empty/count).
- Top: command latch, address/remaining counters, two-state FSM.

## Test plan
- Reset: after reset high one cycle → control_done=1, master_write=0, master_address=0, user_buffer_full=0.
- Single word: push 13, go base 0x10000000 length 4, waitrequest 0 → one beat address 0x10000000 data 13 byteenable 0xF; done=1 next cycle.
- Burst with stalls: push 8 words 1..8, go base 0x100 length 32, waitrequest toggling → addresses 0x100..0x11C in order, data 1..8, outputs stable during each stall.
- Fixed location: push 4 words, fixed=1, base 0x200 length 16 → 4 beats all at 0x200.
- Full/drain: push 33 words idle → full after 32nd, 33rd dropped; go length 128 → 32 beats, full drops after first beat; empty mid-run (length 256) → master_write 0, done stays 0.
- Edge: go length 0 or 3 → no beat, done stays 1; reset asserted after 3rd beat of 8 → master_write 0 next cycle, FIFO empty, done 1.
